demux_channel_sequencer: RTL

//  Upstream control stage for the N-way 1-bit demux: walks an enabled-channel mask,

---
 rtl/demux_channel_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/demux_channel_sequencer.sv
// Sequencer for an N-way 1-bit demux: walks a latched channel mask and holds each
// enabled channel for dwell+1 cycles. Optional macro CONTINUOUS_SCAN_EN wraps the scan.
module demux_channel_sequencer #(
  parameter  int N       = 64,
  parameter  int DWELL_W = 8,
  localparam int SW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [N-1:0]       chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               data_src,
  output logic [SW-1:0]      sel,
  output logic               data_out,
  output logic               chan_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t             state, state_n;
  logic [SW-1:0]      sel_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [N-1:0]       mask_q, mask_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               wrap_q, wrap_n;
  logic [SW:0]        first_hit;
  logic [SW:0]        next_hit;

  // Lowest set bit of m with index >= base (incl) or > base; MSB flags a hit.
  function automatic logic [SW:0] find_set(input logic [N-1:0] m,
                                           input logic [SW-1:0] base,
                                           input logic incl);
    logic [SW:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!r[SW] && m[i] && (incl ? (SW'(i) >= base) : (SW'(i) > base))) begin
        r = {1'b1, SW'(i)};
      end
    end
    return r;
  endfunction

  always_comb begin
    first_hit = find_set(chan_mask, '0, 1'b1);
    next_hit  = find_set(mask_q, sel, 1'b0);
  end

`ifdef CONTINUOUS_SCAN_EN
  logic [SW:0] wrap_hit;
  always_comb wrap_hit = find_set(mask_q, '0, 1'b1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      mask_q  <= mask_n;
      dwell_q <= dwell_n;
      wrap_q  <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    mask_n  = mask_q;
    dwell_n = dwell_q;
    wrap_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_n  = chan_mask;
            dwell_n = dwell;
            if (first_hit[SW]) begin
              state_n = DWELL;
              sel_n   = first_hit[SW-1:0];
              cnt_n   = dwell;
            end else begin
              state_n = DONE;
            end
          end
        end
        DWELL: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (next_hit[SW]) begin
            sel_n = next_hit[SW-1:0];
            cnt_n = dwell_q;
          end else begin
`ifdef CONTINUOUS_SCAN_EN
            // Mask is non-empty here, so the wrap target always exists.
            sel_n  = wrap_hit[SW-1:0];
            cnt_n  = dwell_q;
            wrap_n = 1'b1;
`else
            state_n = DONE;
`endif
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    chan_valid = (state == DWELL);
    busy       = (state == DWELL);
    done       = (state == DONE) | wrap_q;
    data_out   = chan_valid & data_src;
  end

endmodule
